// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, result entry type and range helper for the writeback unit
// Contents: DATA_W, ADDR_W, NREG, PEND_W, IDX_W, wb_entry_t {addr, data}, in_range().
package wb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 16;
  localparam int PEND_W = 3;
  localparam int IDX_W  = (NREG > 1) ? $clog2(NREG) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // One extra bit on the left so NREG == 2**ADDR_W still compares correctly.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(NREG);
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry circular buffer of wb_entry_t results, oldest at head
// Ports: clk, rst (async, active-high); push/push_entry, pop; head, full, empty.
// With WB_BYPASS_EN: slot[i]/slot_vld[i] expose entries in age order (i=0 oldest).
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
`ifdef WB_BYPASS_EN
  ,
  output wb_entry_t        slot     [DEPTH],
  output logic [DEPTH-1:0] slot_vld
`endif
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one wrap bit above the index so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t   mem_q [DEPTH];
  wb_entry_t   mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_entry;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

`ifdef WB_BYPASS_EN
  logic [AW:0] count;
  assign count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot[i]     = mem_q[rd_ptr_q[AW-1:0] + AW'(i)];
      slot_vld[i] = ((AW+1)'(i) < count);
    end
  end
`endif
endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - merges ALU and load results into the register file write port
// Ports: CLK, RESET (async, active-high); alu_valid/alu_ready/alu_addr/alu_data;
// mem_valid/mem_ready/mem_addr/mem_data; iss_valid/iss_addr; q_addr1/2 -> q_busy1/2;
// Waddr/Writedata/RegWr (registered). Optional macro WB_BYPASS_EN adds q_hit1/2, q_data1/2.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              q_busy1,
  output logic              q_busy2,
`ifdef WB_BYPASS_EN
  output logic              q_hit1,
  output logic              q_hit2,
  output logic [DATA_W-1:0] q_data1,
  output logic [DATA_W-1:0] q_data2,
`endif
  output logic [ADDR_W-1:0] Waddr,
  output logic [DATA_W-1:0] Writedata,
  output logic              RegWr
);
  wb_entry_t push_entry;
  wb_entry_t head;
  logic      full, empty, push, pop, mem_acc, alu_acc;

  // Loads win arbitration; readiness looks at pre-pop occupancy only.
  assign mem_ready = !RESET && !full;
  assign alu_ready = !RESET && !full && !mem_valid;
  assign mem_acc   = mem_valid && mem_ready;
  assign alu_acc   = alu_valid && alu_ready;
  assign push      = mem_acc || alu_acc;
  assign pop       = !empty;

  always_comb begin
    push_entry.addr = alu_addr;
    push_entry.data = alu_data;
    if (mem_acc) begin
      push_entry.addr = mem_addr;
      push_entry.data = mem_data;
    end
  end

`ifdef WB_BYPASS_EN
  wb_entry_t        slot [DEPTH];
  logic [DEPTH-1:0] slot_vld;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (CLK),
    .rst        (RESET),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty)
`ifdef WB_BYPASS_EN
    ,
    .slot       (slot),
    .slot_vld   (slot_vld)
`endif
  );

  // Output register: out-of-range heads are consumed without a write and
  // leave Waddr/Writedata at their previous value.
  logic              regwr_q, regwr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_comb begin
    regwr_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (!empty && in_range(head.addr)) begin
      regwr_d = 1'b1;
      waddr_d = head.addr;
      wdata_d = head.data;
    end
  end

  assign RegWr     = regwr_q;
  assign Waddr     = waddr_q;
  assign Writedata = wdata_q;

  // Pending-write scoreboard. The decrement uses the write being loaded into
  // the output register, so busy clears in the same cycle RegWr is presented.
  logic [PEND_W-1:0] cnt_q [NREG];
  logic [PEND_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]   inc_vec, dec_vec;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      inc_vec[r] = iss_valid && in_range(iss_addr) && (iss_addr == ADDR_W'(r));
      dec_vec[r] = regwr_d && (waddr_d == ADDR_W'(r));
      cnt_d[r]   = cnt_q[r];
      if (inc_vec[r] && !dec_vec[r] && (cnt_q[r] != '1)) begin
        cnt_d[r] = cnt_q[r] + PEND_W'(1);
      end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      regwr_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      regwr_q <= regwr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q_busy1 = in_range(q_addr1) && (cnt_q[q_addr1[IDX_W-1:0]] != '0);
  assign q_busy2 = in_range(q_addr2) && (cnt_q[q_addr2[IDX_W-1:0]] != '0);

`ifdef WB_BYPASS_EN
  // Oldest source first so that later (younger) matches overwrite earlier ones.
  always_comb begin
    q_hit1  = 1'b0;
    q_hit2  = 1'b0;
    q_data1 = '0;
    q_data2 = '0;
    if (regwr_q && (waddr_q == q_addr1)) begin
      q_hit1  = 1'b1;
      q_data1 = wdata_q;
    end
    if (regwr_q && (waddr_q == q_addr2)) begin
      q_hit2  = 1'b1;
      q_data2 = wdata_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i] && in_range(slot[i].addr) && (slot[i].addr == q_addr1)) begin
        q_hit1  = 1'b1;
        q_data1 = slot[i].data;
      end
      if (slot_vld[i] && in_range(slot[i].addr) && (slot[i].addr == q_addr2)) begin
        q_hit2  = 1'b1;
        q_data2 = slot[i].data;
      end
    end
  end
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - randomized self-checking bench for writeback_unit against a queue model
module tb_writeback_unit;
  import wb_pkg::*;
  localparam int DEPTH = 4;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              alu_valid, mem_valid, iss_valid;
  logic              alu_ready, mem_ready;
  logic [ADDR_W-1:0] alu_addr, mem_addr, iss_addr, q_addr1, q_addr2;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic              q_busy1, q_busy2;
  logic [ADDR_W-1:0] Waddr;
  logic [DATA_W-1:0] Writedata;
  logic              RegWr;
`ifdef WB_BYPASS_EN
  logic              q_hit1, q_hit2;
  logic [DATA_W-1:0] q_data1, q_data2;
`endif

  always #5 CLK = ~CLK;

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .q_addr1   (q_addr1),
    .q_addr2   (q_addr2),
    .q_busy1   (q_busy1),
    .q_busy2   (q_busy2),
`ifdef WB_BYPASS_EN
    .q_hit1    (q_hit1),
    .q_hit2    (q_hit2),
    .q_data1   (q_data1),
    .q_data2   (q_data2),
`endif
    .Waddr     (Waddr),
    .Writedata (Writedata),
    .RegWr     (RegWr)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  // Reference model: accepted results in order, the presented write, pending counts.
  ent_t              mq[$];
  logic              m_regwr;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  int                m_cnt[NREG];
  logic              alu_acc_m, mem_acc_m;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_busy(input logic [ADDR_W-1:0] a);
    return (int'(a) < NREG) && (m_cnt[a] != 0);
  endfunction

  function automatic logic [DATA_W:0] m_lookup(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] r = '0;
    if (m_regwr && m_waddr == a) r = {1'b1, m_wdata};
    foreach (mq[i]) if (int'(mq[i].addr) < NREG && mq[i].addr == a) r = {1'b1, mq[i].data};
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_regwr = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    alu_acc_m = 1'b0;
    mem_acc_m = 1'b0;
  endtask

  // Called just after a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    bit   full_m;
    ent_t e;
    int   v;
    logic [DATA_W:0] lk;
    #1;
    full_m = (mq.size() >= DEPTH);
    check("mem_ready", mem_ready, !full_m);
    check("alu_ready", alu_ready, !full_m && !mem_valid);
    check("RegWr", RegWr, m_regwr);
    check("Waddr", Waddr, m_waddr);
    check("Writedata", Writedata, m_wdata);
    check("q_busy1", q_busy1, m_busy(q_addr1));
    check("q_busy2", q_busy2, m_busy(q_addr2));
`ifdef WB_BYPASS_EN
    lk = m_lookup(q_addr1);
    check("q_hit1", q_hit1, lk[DATA_W]);
    if (lk[DATA_W]) check("q_data1", q_data1, lk[DATA_W-1:0]);
    lk = m_lookup(q_addr2);
    check("q_hit2", q_hit2, lk[DATA_W]);
    if (lk[DATA_W]) check("q_data2", q_data2, lk[DATA_W-1:0]);
`else
    lk = '0;
`endif
    // Next posedge: arbitration on current occupancy, then retire oldest, then enqueue.
    mem_acc_m = mem_valid && !full_m;
    alu_acc_m = alu_valid && !full_m && !mem_valid;
    m_regwr = 1'b0;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      if (int'(e.addr) < NREG) begin
        m_regwr = 1'b1;
        m_waddr = e.addr;
        m_wdata = e.data;
      end
    end
    if (mem_acc_m) mq.push_back('{mem_addr, mem_data});
    else if (alu_acc_m) mq.push_back('{alu_addr, alu_data});
    for (int r = 0; r < NREG; r++) begin
      v = m_cnt[r];
      if (iss_valid && int'(iss_addr) == r) v++;
      if (m_regwr && int'(m_waddr) == r) v--;
      if (v > 7) v = 7;
      if (v < 0) v = 0;
      m_cnt[r] = v;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic mid_reset();
    #2 RESET = 1'b1;
    #1;
    model_reset();
    check("rst_RegWr", RegWr, 1'b0);
    check("rst_Waddr", Waddr, '0);
    check("rst_Writedata", Writedata, '0);
    check("rst_mem_ready", mem_ready, 1'b0);
    check("rst_alu_ready", alu_ready, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    check("rst_hold_RegWr", RegWr, 1'b0);
    RESET = 1'b0;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    return ADDR_W'($urandom_range(0, 21));
  endfunction

  initial begin
    RESET = 1'b1;
    alu_valid = 0; mem_valid = 0; iss_valid = 0;
    alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
    iss_addr = '0; q_addr1 = '0; q_addr2 = '0;
    model_reset();
    @(negedge CLK);
    check("reset_RegWr", RegWr, 1'b0);
    check("reset_Waddr", Waddr, '0);
    check("reset_Writedata", Writedata, '0);
    check("reset_alu_ready", alu_ready, 1'b0);
    check("reset_mem_ready", mem_ready, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;

    // Single ALU result.
    alu_valid = 1; alu_addr = 3; alu_data = 32'h1234; q_addr1 = 3;
    step();
    alu_valid = 0;
    step();
    check("first_write_RegWr", RegWr, 1'b1);
    check("first_write_Waddr", Waddr, 5'd3);
    check("first_write_data", Writedata, 32'h1234);
    step();

    // Load and ALU together: load first, ALU held until accepted.
    mem_valid = 1; mem_addr = 5; mem_data = 7;
    alu_valid = 1; alu_addr = 6; alu_data = 9;
    step();
    mem_valid = 0;
    step();
    alu_valid = 0;
    repeat (3) step();

    // Two issues to r4, then two writes, then issue and retire in one cycle.
    q_addr1 = 4; q_addr2 = 2;
    iss_valid = 1; iss_addr = 4;
    repeat (2) step();
    iss_valid = 0;
    alu_valid = 1; alu_addr = 4; alu_data = 32'h44;
    step();
    alu_data = 32'h45;
    step();
    alu_valid = 0;
    repeat (2) step();
    alu_valid = 1; alu_addr = 4; alu_data = 32'h46;
    step();
    alu_valid = 0; iss_valid = 1; iss_addr = 4;
    step();
    iss_valid = 0;
    repeat (2) step();

    // Out-of-range destination, and out-of-range issue.
    alu_valid = 1; alu_addr = 20; alu_data = 32'hDEAD;
    iss_valid = 1; iss_addr = 20; q_addr2 = 20;
    step();
    alu_valid = 0; iss_valid = 0;
    repeat (2) step();

    // Entry for r2 visible to bypass before retirement, then reset mid-stream.
    q_addr1 = 2;
    alu_valid = 1; alu_addr = 2; alu_data = 32'hAA;
    step();
    mem_valid = 1; mem_addr = 7; mem_data = 32'h77;
    step();
    mid_reset();
    repeat (3) step();

    // Randomized traffic with the hold rule obeyed by both producers.
    for (int n = 0; n < 1500; n++) begin
      if (!(alu_valid && !alu_acc_m)) begin
        alu_valid = ($urandom_range(0, 1) == 1);
        alu_addr  = rnd_addr();
        alu_data  = $urandom;
      end
      if (!(mem_valid && !mem_acc_m)) begin
        mem_valid = ($urandom_range(0, 2) == 0);
        mem_addr  = rnd_addr();
        mem_data  = $urandom;
      end
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_addr  = rnd_addr();
      q_addr1   = ($urandom_range(0, 1) == 1) ? alu_addr : rnd_addr();
      q_addr2   = rnd_addr();
      if (n % 500 == 250) mid_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
